// File: rtl/burst_mul_buffer.sv
// burst_mul_buffer: fetches BURST operand pairs over a req_ab/ack handshake,
// stores either each product or the running sum of products, then streams the
// stored results out under a valid/dout_ready handshake.
module burst_mul_buffer #(
    parameter  int A_W   = 8,
    parameter  int B_W   = 8,
    parameter  int OUT_W = 16,
    parameter  int BURST = 8,
    localparam int LVL_W = $clog2(BURST + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             halt,
    input  logic             mode,
    input  logic [A_W-1:0]   a,
    input  logic [B_W-1:0]   b,
    input  logic             ack,
    output logic             req_ab,
    output logic [OUT_W-1:0] dout,
    output logic             valid,
    input  logic             dout_ready,
    output logic [LVL_W-1:0] level,
    output logic             busy
);

    localparam int IDX_W  = $clog2(BURST);
    localparam int PROD_W = (A_W + B_W > OUT_W) ? (A_W + B_W) : OUT_W;
    localparam logic [LVL_W-1:0] LAST = LVL_W'(BURST - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [LVL_W-1:0]   wr_q, wr_d;
    logic [LVL_W-1:0]   rd_q, rd_d;
    logic [OUT_W-1:0]   acc_q, acc_d;
    logic               mode_q, mode_d;
    logic [OUT_W-1:0]   resultMem_q [BURST];

    logic               wrEn;
    logic [OUT_W-1:0]   wrData;
    logic [OUT_W-1:0]   prodMod;
    logic [OUT_W-1:0]   accSum;

    // The full product is formed at the wider of the two widths and then
    // truncated, which is the same as taking it modulo 2^OUT_W.
    assign prodMod = OUT_W'(PROD_W'(a) * PROD_W'(b));
    assign accSum  = acc_q + prodMod;

    // Control registers: state, indices, accumulator and latched mode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            wr_q    <= '0;
            rd_q    <= '0;
            acc_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            acc_q   <= acc_d;
            mode_q  <= mode_d;
        end
    end

    // Result storage needs no reset: its contents are only read after a fill.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            resultMem_q[wr_q[IDX_W-1:0]] <= wrData;
        end
    end

    // Next-state logic; halt overrides every other input in every state.
    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        acc_d   = acc_q;
        mode_d  = mode_q;
        wrEn    = 1'b0;
        wrData  = prodMod;
        if (halt) begin
            state_d = IDLE;
            wr_d    = '0;
            rd_d    = '0;
            acc_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = FETCH;
                        wr_d    = '0;
                        rd_d    = '0;
                        acc_d   = '0;
                        mode_d  = mode;
                    end
                end
                FETCH: begin
                    if (ack) begin
                        wrEn = 1'b1;
                        if (mode_q) begin
                            wrData = accSum;
                            acc_d  = accSum;
                        end
                        wr_d = wr_q + 1'b1;
                        if (wr_q == LAST) begin
                            state_d = DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (dout_ready) begin
                        rd_d = rd_q + 1'b1;
                        if (rd_q == LAST) begin
                            state_d = IDLE;
                            wr_d    = '0;
                            rd_d    = '0;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign req_ab = (state_q == FETCH);
    assign valid  = (state_q == DRAIN);
    assign busy   = (state_q != IDLE);
    assign level  = wr_q - rd_q;
    assign dout   = (state_q == DRAIN) ? resultMem_q[rd_q[IDX_W-1:0]] : '0;

endmodule

// File: tb/tb_burst_mul_buffer.sv
// tb_burst_mul_buffer: directed scenarios followed by randomized traffic,
// checked against a queue-based reference model of the burst buffer.
module tb_burst_mul_buffer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        halt;
    logic        mode;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        ack;
    logic        req_ab;
    logic [15:0] dout;
    logic        valid;
    logic        dout_ready;
    logic [3:0]  level;
    logic        busy;

    int compared;
    int mismatched;

    // Reference model: phase 0=idle, 1=fetching, 2=draining.
    int mPhase;
    int mRes[$];
    int mCons;
    int mAcc;
    bit mMode;

    int gotQ[$];
    int expQ[$];

    burst_mul_buffer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .halt       (halt),
        .mode       (mode),
        .a          (a),
        .b          (b),
        .ack        (ack),
        .req_ab     (req_ab),
        .dout       (dout),
        .valid      (valid),
        .dout_ready (dout_ready),
        .level      (level),
        .busy       (busy)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mPhase = 0;
        mRes.delete();
        mCons  = 0;
        mAcc   = 0;
        mMode  = 1'b0;
    endtask

    // Advance the model by one rising edge using the inputs now applied.
    task automatic modelStep();
        int p;
        if (halt) begin
            mPhase = 0;
            mRes.delete();
            mCons = 0;
            mAcc  = 0;
        end else if (mPhase == 0) begin
            if (start) begin
                mPhase = 1;
                mRes.delete();
                mCons = 0;
                mAcc  = 0;
                mMode = mode;
            end
        end else if (mPhase == 1) begin
            if (ack) begin
                p = (int'(a) * int'(b)) % 65536;
                if (mMode) begin
                    mAcc = (mAcc + p) % 65536;
                    mRes.push_back(mAcc);
                end else begin
                    mRes.push_back(p);
                end
                if (mRes.size() == 8) mPhase = 2;
            end
        end else begin
            if (dout_ready) begin
                mCons++;
                if (mCons == 8) begin
                    mPhase = 0;
                    mRes.delete();
                    mCons = 0;
                end
            end
        end
    endtask

    task automatic checkOutput();
        int expDout;
        expDout = (mPhase == 2) ? mRes[mCons] : 0;
        chk("req_ab", 32'(req_ab), 32'(mPhase == 1));
        chk("valid",  32'(valid),  32'(mPhase == 2));
        chk("busy",   32'(busy),   32'(mPhase != 0));
        chk("level",  32'(level),  32'(mRes.size() - mCons));
        chk("dout",   32'(dout),   32'(expDout));
    endtask

    // Apply one cycle of inputs, clock it, then check all outputs.
    task automatic applyStimulus(input bit st, input bit hl, input bit md, input bit ak,
                                 input bit rdy, input logic [7:0] aa, input logic [7:0] bb);
        start      = st;
        halt       = hl;
        mode       = md;
        ack        = ak;
        dout_ready = rdy;
        a          = aa;
        b          = bb;
        if (valid === 1'b1 && rdy && !hl) gotQ.push_back(int'(dout));
        modelStep();
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic compareGot(input string tag);
        chk({tag, "_count"}, 32'(gotQ.size()), 32'(expQ.size()));
        for (int i = 0; i < expQ.size() && i < gotQ.size(); i++) begin
            chk(tag, 32'(gotQ[i]), 32'(expQ[i]));
        end
    endtask

    task automatic drainAll(input string tag, input bit toggle);
        int n;
        n = 0;
        while (mPhase == 2 && n < 64) begin
            applyStimulus(0, 0, 0, 0, toggle ? ((n % 4) == 0 || (n % 4) == 3) : 1'b1, 8'd0, 8'd0);
            n++;
        end
        chk({tag, "_drainDone"}, 32'(busy), 32'd0);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b0;
        start      = 1'b0;
        halt       = 1'b0;
        mode       = 1'b0;
        ack        = 1'b0;
        dout_ready = 1'b0;
        a          = '0;
        b          = '0;
        modelReset();

        #12;
        chk("rst_req",   32'(req_ab), 32'd0);
        chk("rst_valid", 32'(valid),  32'd0);
        chk("rst_busy",  32'(busy),   32'd0);
        chk("rst_level", 32'(level),  32'd0);
        chk("rst_dout",  32'(dout),   32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Basic burst: products 2,4,...,16.
        $display("[TB] basic burst");
        gotQ.delete();
        expQ.delete();
        applyStimulus(1, 0, 0, 0, 0, 8'd0, 8'd0);
        chk("start_req", 32'(req_ab), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(0, 0, 0, 1, 1, 8'(i), 8'd2);
            expQ.push_back(2 * i);
        end
        chk("first_valid", 32'(valid), 32'd1);
        chk("first_dout",  32'(dout),  32'd2);
        chk("full_level",  32'(level), 32'd8);
        drainAll("basic", 0);
        compareGot("basic");

        // Gapped fetch: ack drops for three cycles before the last pair.
        $display("[TB] gapped fetch");
        gotQ.delete();
        applyStimulus(1, 0, 0, 0, 0, 8'd0, 8'd0);
        for (int i = 1; i <= 7; i++) applyStimulus(0, 0, 0, 1, 0, 8'(i), 8'd2);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0, 1, 8'd77, 8'd2);
            chk("gap_req",   32'(req_ab), 32'd1);
            chk("gap_level", 32'(level),  32'd7);
        end
        applyStimulus(0, 0, 0, 1, 0, 8'd8, 8'd2);
        drainAll("gapped", 0);
        compareGot("gapped");

        // Backpressure: dout_ready pattern 1,0,0,1 during drain.
        $display("[TB] backpressure");
        gotQ.delete();
        applyStimulus(1, 0, 0, 0, 0, 8'd0, 8'd0);
        for (int i = 1; i <= 8; i++) applyStimulus(0, 0, 0, 1, 0, 8'(i), 8'd2);
        drainAll("backpressure", 1);
        compareGot("backpressure");

        // Accumulate: running sums 1,3,6,...,36.
        $display("[TB] accumulate");
        gotQ.delete();
        expQ.delete();
        applyStimulus(1, 0, 1, 0, 0, 8'd0, 8'd0);
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(0, 0, 0, 1, 1, 8'(i), 8'd1);
            expQ.push_back(i * (i + 1) / 2);
        end
        drainAll("accum", 0);
        compareGot("accum");

        // Accumulate wrap: k*65025 modulo 65536.
        $display("[TB] accumulate wrap");
        gotQ.delete();
        expQ.delete();
        applyStimulus(1, 0, 1, 0, 0, 8'd0, 8'd0);
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(0, 0, 1, 1, 1, 8'd255, 8'd255);
            expQ.push_back((i * 65025) % 65536);
        end
        drainAll("wrap", 0);
        compareGot("wrap");

        // Halt after four transfers, then a fresh burst.
        $display("[TB] halt mid-fetch");
        applyStimulus(1, 0, 0, 0, 0, 8'd0, 8'd0);
        for (int i = 1; i <= 4; i++) applyStimulus(0, 0, 0, 1, 0, 8'(i + 10), 8'd3);
        applyStimulus(0, 1, 0, 0, 0, 8'd0, 8'd0);
        chk("halt_busy",  32'(busy),  32'd0);
        chk("halt_level", 32'(level), 32'd0);
        gotQ.delete();
        expQ.delete();
        applyStimulus(1, 0, 0, 0, 0, 8'd0, 8'd0);
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(0, 0, 0, 1, 1, 8'(i), 8'd5);
            expQ.push_back(5 * i);
        end
        drainAll("afterHalt", 0);
        compareGot("afterHalt");

        // Halt together with ack: that pair must not be stored.
        $display("[TB] halt with ack");
        applyStimulus(1, 0, 0, 0, 0, 8'd0, 8'd0);
        for (int i = 1; i <= 7; i++) applyStimulus(0, 0, 0, 1, 0, 8'(i), 8'd1);
        applyStimulus(0, 1, 0, 1, 0, 8'd99, 8'd1);
        chk("haltAck_busy",  32'(busy),  32'd0);
        chk("haltAck_valid", 32'(valid), 32'd0);
        chk("haltAck_level", 32'(level), 32'd0);

        // Asynchronous reset in the middle of a drain.
        $display("[TB] reset mid-drain");
        applyStimulus(1, 0, 0, 0, 0, 8'd0, 8'd0);
        for (int i = 1; i <= 8; i++) applyStimulus(0, 0, 0, 1, 0, 8'(i), 8'd4);
        applyStimulus(0, 0, 0, 0, 1, 8'd0, 8'd0);
        applyStimulus(0, 0, 0, 0, 1, 8'd0, 8'd0);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid", 32'(valid),  32'd0);
        chk("arst_req",   32'(req_ab), 32'd0);
        chk("arst_busy",  32'(busy),   32'd0);
        chk("arst_level", 32'(level),  32'd0);
        chk("arst_dout",  32'(dout),   32'd0);
        modelReset();
        dout_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput();

        // Randomized traffic against the reference model.
        $display("[TB] random traffic");
        for (int i = 0; i < 1500; i++) begin
            applyStimulus(($urandom % 3) == 0, ($urandom % 50) == 0, 1'($urandom),
                          ($urandom % 3) != 0, ($urandom % 3) != 0,
                          8'($urandom), 8'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
